// File: rtl/jtkiwi_subbus_if.sv
// rtl/jtkiwi_subbus_if.sv - Kiwi sub-CPU bus bundle between Z80 wrapper and ROM/RAM/FM/cabinet
interface jtkiwi_subbus_if #(
   parameter int BANKW = 2,
   parameter int NCAB  = 3
);
   logic [15:0]         A;
   logic                mreq_n;
   logic                rfsh_n;
   logic                iorq_n;
   logic                wr_n;
   logic [7:0]          cpu_dout;
   logic                LVBL;
   logic                mshramen;
   logic [7:0]          rom_data;
   logic [7:0]          ram_dout;
   logic [7:0]          fm_dout;
   logic [8*NCAB-1:0]   cab_in;
   logic [13+BANKW:0]   rom_addr;
   logic                rom_cs;
   logic                fm_cs;
   logic                ram_cs;
   logic [7:0]          din;
   logic [BANKW-1:0]    bank;
   logic                mcu_rst;
   logic                int_n;
   logic                dev_busy;
   logic                wdog_rst;

   modport master (
      output A, mreq_n, rfsh_n, iorq_n, wr_n, cpu_dout, LVBL, mshramen,
             rom_data, ram_dout, fm_dout, cab_in,
      input  rom_addr, rom_cs, fm_cs, ram_cs, din, bank, mcu_rst, int_n, dev_busy, wdog_rst
   );

   modport slave (
      input  A, mreq_n, rfsh_n, iorq_n, wr_n, cpu_dout, LVBL, mshramen,
             rom_data, ram_dout, fm_dout, cab_in,
      output rom_addr, rom_cs, fm_cs, ram_cs, din, bank, mcu_rst, int_n, dev_busy, wdog_rst
   );
endinterface

// File: rtl/jtkiwi_subbus.sv
// rtl/jtkiwi_subbus.sv - Kiwi sub-CPU bus decode, ROM banking, IRQ latch; JTKIWI_WDOG_EN adds frame watchdog
module jtkiwi_subbus #(
   parameter int BANKW       = 2,
   parameter int NCAB        = 3,
   parameter int WDOG_FRAMES = 8
) (
   input  logic             clk,
   input  logic             comb_rstn,
   jtkiwi_subbus_if.slave   bus
);
   localparam int AW = 14 + BANKW;

   logic             acc;
   logic             rom_cs_d, bank_cs_d, fm_cs_d, cab_cs_d, ram_cs_d;
   logic             rom_cs_q, bank_cs_q, fm_cs_q, cab_cs_q, ram_cs_q;
   logic [7:0]       cab_byte;
   logic [7:0]       din_d, din_q;
   logic [BANKW-1:0] bank_q;
   logic             mcu_rst_q;
   logic             bank_wr;
   logic             lvbl_q;
   logic             lvbl_fall;
   logic             int_n_d, int_n_q;

   assign acc = ~bus.mreq_n & bus.rfsh_n;

   always_comb begin
      rom_cs_d  = 1'b0;
      bank_cs_d = 1'b0;
      fm_cs_d   = 1'b0;
      cab_cs_d  = 1'b0;
      ram_cs_d  = 1'b0;
      if (acc) begin
         case (bus.A[15:12])
            4'hA:       bank_cs_d = 1'b1;
            4'hB:       fm_cs_d   = 1'b1;
            4'hC:       cab_cs_d  = 1'b1;
            4'hD, 4'hE: ram_cs_d  = 1'b1;
            4'hF:       ;
            default:    rom_cs_d  = 1'b1;
         endcase
      end
   end

   // Cabinet bytes beyond NCAB read as open bus zero
   always_comb begin
      cab_byte = 8'h00;
      for (int k = 0; k < NCAB; k++) begin
         if (bus.A[2:0] == 3'(k)) cab_byte = bus.cab_in[8*k +: 8];
      end
   end

   always_comb begin
      din_d = 8'h00;
      if (rom_cs_q)      din_d = bus.rom_data;
      else if (ram_cs_q) din_d = bus.ram_dout;
      else if (fm_cs_q)  din_d = bus.fm_dout;
      else if (cab_cs_q) din_d = cab_byte;
   end

   assign bank_wr   = bank_cs_q & ~bus.wr_n;
   assign lvbl_fall = lvbl_q & ~bus.LVBL;

   always_comb begin
      int_n_d = int_n_q;
      if (lvbl_fall)        int_n_d = 1'b0;
      else if (!bus.iorq_n) int_n_d = 1'b1;
   end

   always_ff @(posedge clk or negedge comb_rstn) begin
      if (!comb_rstn) begin
         rom_cs_q  <= 1'b0;
         bank_cs_q <= 1'b0;
         fm_cs_q   <= 1'b0;
         cab_cs_q  <= 1'b0;
         ram_cs_q  <= 1'b0;
         din_q     <= 8'h00;
         bank_q    <= '0;
         mcu_rst_q <= 1'b0;
         lvbl_q    <= 1'b1;
         int_n_q   <= 1'b1;
      end else begin
         rom_cs_q  <= rom_cs_d;
         bank_cs_q <= bank_cs_d;
         fm_cs_q   <= fm_cs_d;
         cab_cs_q  <= cab_cs_d;
         ram_cs_q  <= ram_cs_d;
         din_q     <= din_d;
         lvbl_q    <= bus.LVBL;
         int_n_q   <= int_n_d;
         if (bank_wr) begin
            bank_q    <= bus.cpu_dout[BANKW-1:0];
            mcu_rst_q <= bus.cpu_dout[BANKW];
         end
      end
   end

`ifdef JTKIWI_WDOG_EN
   logic [7:0] wdog_cnt_d, wdog_cnt_q;
   logic       wdog_d, wdog_q;

   // A bank write is the software's sign of life and beats a same-clock frame edge
   always_comb begin
      wdog_cnt_d = wdog_cnt_q;
      wdog_d     = 1'b0;
      if (bank_wr) begin
         wdog_cnt_d = 8'd0;
      end else if (lvbl_fall) begin
         if (wdog_cnt_q + 8'd1 == 8'(WDOG_FRAMES)) begin
            wdog_cnt_d = 8'd0;
            wdog_d     = 1'b1;
         end else begin
            wdog_cnt_d = wdog_cnt_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge comb_rstn) begin
      if (!comb_rstn) begin
         wdog_cnt_q <= 8'd0;
         wdog_q     <= 1'b0;
      end else begin
         wdog_cnt_q <= wdog_cnt_d;
         wdog_q     <= wdog_d;
      end
   end

   assign bus.wdog_rst = wdog_q;
`else
   assign bus.wdog_rst = 1'b0;
`endif

   // Bank comes from the register output, so a write in flight never affects this cycle
   assign bus.rom_addr = bus.A[15] ? AW'(16'h8000) + AW'({bank_q, bus.A[12:0]})
                                   : AW'(bus.A);

   assign bus.rom_cs   = rom_cs_q;
   assign bus.fm_cs    = fm_cs_q;
   assign bus.ram_cs   = ram_cs_q;
   assign bus.din      = din_q;
   assign bus.bank     = bank_q;
   assign bus.mcu_rst  = mcu_rst_q;
   assign bus.int_n    = int_n_q;
   assign bus.dev_busy = bus.mshramen & ram_cs_q;
endmodule
